serial_subtractor_ctrl: RTL

Bit-serial N-bit subtractor controller. It sequences a single 1-bit full-subtractor cell, `fs_using_mux`, over WIDTH clock cycles to compute `a - b - bin`, LSB first. The block accepts a start request, latches operands, and steps the cell one bit per cycle. It then returns the full-width difference and final borrow with a done pulse. It sits between a requesting controller and the shared subtractor cell, trading area for latency.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/fs_using_mux.sv | 18 +
 rtl/serial_subtractor_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial subtractor controller.
// Pure declarations, no logic; no flow control here.
package serial_sub_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_e;

    // Bit-position counter width; a 1-bit build still needs one counter bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fs_using_mux.sv
// 1-bit full subtractor (a - b - bin) built from 2:1 muxes selected by the minuend bit.
// Purely combinational, zero latency; no backpressure.
module fs_using_mux (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic borrow
);

    logic b_x_bin;

    assign b_x_bin = b ^ bin;
    assign diff    = a ? ~b_x_bin : b_x_bin;
    // With a=1 only both b and bin set borrow; with a=0 either one does.
    assign borrow  = a ? (b & bin) : (b | bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Steps one shared full-subtractor cell over WIDTH cycles, LSB first, to produce a - b - bin.
// Done pulses WIDTH cycles after the accepting edge; start is ignored while busy (no queuing).
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] diff_sh_q;
    logic [WIDTH-1:0] diff_sh_d;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             cell_diff;
    logic             cell_borrow;

    fs_using_mux u_cell (
        .a      (a_sh_q[0]),
        .b      (b_sh_q[0]),
        .bin    (br_q),
        .diff   (cell_diff),
        .borrow (cell_borrow)
    );

    // New bit enters at the MSB so after WIDTH steps bit 0 sits at position 0.
    always_comb begin
        diff_sh_d = WIDTH'({cell_diff, diff_sh_q} >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            br_q      <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q    <= a;
                        b_sh_q    <= b;
                        br_q      <= bin;
                        cnt_q     <= '0;
                        diff_sh_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q    <= a_sh_q >> 1;
                    b_sh_q    <= b_sh_q >> 1;
                    diff_sh_q <= diff_sh_d;
                    br_q      <= cell_borrow;
                    if (cnt_q == CNT_LAST) begin
                        done_q  <= 1'b1;
                        diff_q  <= diff_sh_d;
                        bout_q  <= cell_borrow;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule
